uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter between N byte-stream requesters with round-robin, message-locked grants.
//  A granted requester keeps the transmitter until its byte flagged req_last has been sent, so messages never interleave.

---
 rtl/uart_tx_arbiter_pkg.sv | 17 +
 rtl/uart_rr_pick.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 106 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit arbiter: Gray-coded FSM states and a
// helper that sizes requester index fields.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_ISSUE = 2'b01,
    ARB_WAIT  = 2'b11,
    ARB_REL   = 2'b10,
    ARB_XXX   = 'x
  } uart_arb_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping at N_REQ-1.
// Purely combinational so it can be shared by other dispatchers.
module uart_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]           req,
  input  logic [id_width(N_REQ)-1:0] ptr,
  output logic                       found,
  output logic [id_width(N_REQ)-1:0] id
);

  localparam int IDW = id_width(N_REQ);

  logic [IDW-1:0] cand [N_REQ];

  always_comb begin
    found = 1'b0;
    id    = '0;
    // cand[0] is the highest-priority index (the one right after ptr)
    for (int k = 0; k < N_REQ; k++) begin
      cand[k] = IDW'((int'(ptr) + k + 1) % N_REQ);
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[cand[k]]) begin
        found = 1'b1;
        id    = cand[k];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte streams with round-robin,
// message-locked grants; one byte per tx_start, next byte only after tx_done.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int HOLD_TMO = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [8*N_REQ-1:0]         req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       grant_valid,
  output logic [id_width(N_REQ)-1:0] grant_id,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  output logic                       tmo_err
);

  localparam int IDW = id_width(N_REQ);
  localparam int CW  = (HOLD_TMO > 0) ? $clog2(HOLD_TMO + 1) : 1;

  uart_arb_e      state, state_nxt;
  logic [IDW-1:0] rr_ptr, pick_id;
  logic           pick_found, last;
  logic           owner_vld, grant_fire, issue_fire, hold_idle, tmo_fire, rel_fire;
  logic [CW-1:0]  hold_cnt;

  uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .id    (pick_id)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (pick_found) state_nxt = ARB_ISSUE;
      ARB_ISSUE: begin
        if (issue_fire)    state_nxt = ARB_WAIT;
        else if (tmo_fire) state_nxt = ARB_REL;
      end
      ARB_WAIT:  if (tx_done) state_nxt = last ? ARB_REL : ARB_ISSUE;
      ARB_REL:   state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_XXX;
    endcase
  end

  // Strobes feeding the registered outputs; a busy TX core freezes the hold counter.
  always_comb begin
    owner_vld  = req_valid[grant_id];
    grant_fire = (state == ARB_IDLE) && pick_found;
    issue_fire = (state == ARB_ISSUE) && owner_vld && !tx_busy;
    hold_idle  = (state == ARB_ISSUE) && !owner_vld;
    tmo_fire   = hold_idle && (HOLD_TMO != 0) && (32'(hold_cnt) + 1 == HOLD_TMO);
    rel_fire   = (state == ARB_REL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      req_ready   <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      tmo_err     <= 1'b0;
      rr_ptr      <= IDW'(N_REQ - 1);
      hold_cnt    <= '0;
      last        <= 1'b0;
    end else begin
      tx_start  <= issue_fire;
      tmo_err   <= tmo_fire;
      req_ready <= issue_fire ? (N_REQ'(1) << grant_id) : '0;
      if (grant_fire) begin
        grant_valid <= 1'b1;
        grant_id    <= pick_id;
      end
      if (rel_fire) begin
        grant_valid <= 1'b0;
        rr_ptr      <= grant_id;
      end
      if (grant_fire || issue_fire) hold_cnt <= '0;
      else if (hold_idle)           hold_cnt <= hold_cnt + CW'(1);
      if (issue_fire) begin
        tx_data <= 8'(req_data >> {grant_id, 3'b000});
        last    <= req_last[grant_id];
      end
    end
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
  a_start_origin: assert property (@(posedge clk) disable iff (!rst_n)
                                   tx_start |-> ($past(state) == ARB_ISSUE && !$past(tx_busy)));
  a_id_range:     assert property (@(posedge clk) 32'(grant_id) < N_REQ);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized message traffic,
// checked against queue-based requester/TX-core models and a round-robin reference.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TMO = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           grant_valid;
  logic [1:0]     grant_id;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic           tx_done;
  logic           tmo_err;

  uart_tx_arbiter #(.N_REQ(N), .HOLD_TMO(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tmo_err     (tmo_err)
  );

  always #5 clk = ~clk;

  // Per-requester byte queues: {last, data}
  logic [8:0] mem [N][64];
  int         hd [N];
  int         tl [N];
  int         gap [N];
  bit         en [N];

  int         n_assert = 0;
  int         n_fail = 0;
  int         tx_cnt = 0;
  int         tx_starts = 0;
  int         tx_len_min = 10;
  int         tx_len_max = 10;
  int         gap_max = 0;
  int         last_owner = N - 1;
  int         open_msg = -1;
  bit         gv_prev = 1'b0;
  int         grant_log [$];
  int         wire_id [$];
  logic [7:0] wire_dat [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic l);
    mem[i][tl[i]] = {l, d};
    tl[i]++;
  endtask

  function automatic bit drained();
    for (int i = 0; i < N; i++) if (hd[i] < tl[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]     = en[i] && gap[i] == 0 && hd[i] < tl[i];
      req_data[i*8+:8] = req_valid[i] ? mem[i][hd[i]][7:0] : 8'h00;
      req_last[i]      = req_valid[i] ? mem[i][hd[i]][8] : 1'b0;
    end
  endtask

  // One clock: sample DUT after the edge, update models and checks, drive next inputs.
  task automatic step();
    logic [N-1:0] rv;
    bit           rst_seen;
    int           exp_id;
    rv       = req_valid;
    rst_seen = !rst_n;
    @(posedge clk);
    #1;
    tx_done = 1'b0;
    if (rst_seen) begin
      last_owner = N - 1;
      open_msg   = -1;
    end
    if (grant_valid && !gv_prev && !rst_seen) begin
      exp_id = -1;
      for (int k = 1; k <= N; k++)
        if (exp_id < 0 && rv[(last_owner + k) % N]) exp_id = (last_owner + k) % N;
      check("rr_grant", 32'(grant_id), exp_id);
      grant_log.push_back(int'(grant_id));
      last_owner = int'(grant_id);
    end
    gv_prev = grant_valid;
    if (tx_start || req_ready != '0) begin
      check("start_with_ready", 32'(tx_start), 32'(req_ready != '0));
      check("ready_is_owner", 32'(req_ready), 32'(1) << grant_id);
    end
    for (int i = 0; i < N; i++) if (gap[i] > 0) gap[i]--;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        if (hd[i] < tl[i]) begin
          check("tx_data", 32'(tx_data), 32'(mem[i][hd[i]][7:0]));
          if (open_msg >= 0) check("no_interleave", i, open_msg);
          open_msg = mem[i][hd[i]][8] ? -1 : i;
          wire_id.push_back(i);
          wire_dat.push_back(tx_data);
          hd[i]++;
          gap[i] = int'($urandom_range(gap_max, 0));
        end else begin
          check("spurious_ready", 32'(req_ready[i]), 0);
        end
      end
    end
    if (tmo_err) open_msg = -1;
    if (tx_start) begin
      tx_starts++;
      tx_cnt = int'($urandom_range(tx_len_max, tx_len_min));
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) tx_done = 1'b1;
    end
    tx_busy = (tx_cnt > 0);
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      en[i] = 1'b0; hd[i] = 0; tl[i] = 0; gap[i] = 0;
    end
    drive();
    repeat (2) step();
    rst_n = 1'b1;
    grant_log.delete();
    wire_id.delete();
    wire_dat.delete();
  endtask

  task automatic wait_quiet(input int budget, input string tag);
    int c;
    c = 0;
    while (!(drained() && !grant_valid && tx_cnt == 0) && c < budget) begin
      step();
      c++;
    end
    check(tag, 32'(drained() && !grant_valid && tx_cnt == 0), 1);
  endtask

  initial begin
    int c, base, total, nmsg, len;
    int rr5 [5]   = '{0, 1, 2, 3, 0};
    int rr4 [4]   = '{0, 1, 3, 0};
    int lk_id [4] = '{0, 0, 0, 1};
    int lk_dat [4] = '{'h11, 'h22, 'h33, 'h44};

    rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    tx_busy = 1'b0; tx_done = 1'b0;
    for (int i = 0; i < N; i++) begin
      en[i] = 1'b0; hd[i] = 0; tl[i] = 0; gap[i] = 0;
    end

    // Reset with every requester valid, then round-robin over 1-byte messages
    for (int i = 0; i < N; i++) begin
      push(i, 8'(8'h30 + i), 1'b1);
      en[i] = 1'b1;
    end
    push(0, 8'h40, 1'b1);
    drive();
    repeat (3) begin
      step();
      check("rst_tx_start", 32'(tx_start), 0);
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_grant_valid", 32'(grant_valid), 0);
    end
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_tmo_err", 32'(tmo_err), 0);
    rst_n = 1'b1;
    wait_quiet(400, "rr_all_drain");
    check("rr_all_count", grant_log.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < grant_log.size()) check("rr_all_order", grant_log[k], rr5[k]);

    // Single byte: grant one edge after request, tx_start one edge later
    do_reset();
    tx_len_min = 10; tx_len_max = 10;
    push(0, 8'hA5, 1'b1);
    en[0] = 1'b1;
    drive();
    step();
    check("single_grant_e1", 32'(grant_valid), 1);
    check("single_no_start_e1", 32'(tx_start), 0);
    step();
    check("single_start_e2", 32'(tx_start), 1);
    check("single_data", 32'(tx_data), 32'h0A5);
    c = 0;
    while (!tx_done && c < 30) begin step(); c++; end
    check("single_done_bound", 32'(c < 30), 1);
    step();
    check("single_held_after_done", 32'(grant_valid), 1);
    step();
    check("single_released", 32'(grant_valid), 0);

    // Message lock: req0 sends 3 bytes before req1 gets the wire
    do_reset();
    tx_len_min = 3; tx_len_max = 6;
    push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b1);
    push(1, 8'h44, 1'b1);
    en[0] = 1'b1; en[1] = 1'b1;
    drive();
    wait_quiet(300, "lock_drain");
    check("lock_len", wire_dat.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < wire_dat.size()) begin
        check("lock_id", wire_id[k], lk_id[k]);
        check("lock_data", 32'(wire_dat[k]), lk_dat[k]);
      end

    // Round-robin with requester 2 idle
    do_reset();
    push(0, 8'hA1, 1'b1); push(0, 8'hA2, 1'b1);
    push(1, 8'hB1, 1'b1); push(3, 8'hD1, 1'b1);
    en[0] = 1'b1; en[1] = 1'b1; en[3] = 1'b1;
    drive();
    wait_quiet(400, "rr_skip_drain");
    check("rr_skip_count", grant_log.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < grant_log.size()) check("rr_skip_order", grant_log[k], rr4[k]);

    // Hold timeout: req1 stalls mid-message, req2 waits
    do_reset();
    tx_len_min = 4; tx_len_max = 4;
    push(1, 8'hB1, 1'b0);
    push(2, 8'hC2, 1'b1);
    en[1] = 1'b1; en[2] = 1'b1;
    drive();
    c = 0;
    while (!tx_done && c < 40) begin step(); c++; end
    check("tmo_done_bound", 32'(c < 40), 1);
    // one edge for the arbiter to take tx_done, then TMO idle cycles in ISSUE
    c = 0;
    while (!tmo_err && c < 30) begin step(); c++; end
    check("tmo_latency", c, 1 + TMO);
    step();
    check("tmo_pulse_width", 32'(tmo_err), 0);
    check("tmo_grant_drop", 32'(grant_valid), 0);
    wait_quiet(100, "tmo_drain");
    check("tmo_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) check("tmo_next_owner", grant_log[1], 2);

    // Reset while byte 2 is in flight: no further tx_start after tx_done
    do_reset();
    tx_len_min = 8; tx_len_max = 8;
    push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b1);
    en[0] = 1'b1;
    drive();
    base = tx_starts;
    c = 0;
    while (tx_starts - base < 2 && c < 100) begin step(); c++; end
    check("abort_second_start", tx_starts - base, 2);
    rst_n = 1'b0;
    en[0] = 1'b0;
    drive();
    step();
    check("abort_grant", 32'(grant_valid), 0);
    check("abort_ready", 32'(req_ready), 0);
    check("abort_start", 32'(tx_start), 0);
    rst_n = 1'b1;
    hd[0] = 0; tl[0] = 0;
    drive();
    base = tx_starts;
    repeat (20) step();
    check("abort_no_start", tx_starts - base, 0);
    check("abort_idle", 32'(grant_valid), 0);

    // Random messages with random inter-byte gaps and TX lengths
    for (int r = 0; r < 3; r++) begin
      do_reset();
      tx_len_min = 2; tx_len_max = 9; gap_max = 2;
      total = 0;
      for (int i = 0; i < N; i++) begin
        nmsg = int'($urandom_range(4, 0));
        for (int m = 0; m < nmsg; m++) begin
          len = int'($urandom_range(4, 1));
          for (int b = 0; b < len; b++) begin
            push(i, 8'($urandom), b == len - 1);
            total++;
          end
        end
        en[i] = 1'b1;
      end
      drive();
      wait_quiet(5000, "rand_drain");
      check("rand_bytes", wire_dat.size(), total);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
